// File: rtl/arisc_pkg.sv
// -----------------------------------------------------------------------------
// arisc_pkg
//   Shared types and widths for the A-RISC 8-bit accumulator CPU.
//   - W_INSTR / W_DATA / W_ADDR : instruction, data and address widths
//   - opcode_e                  : 8-bit opcode encoding (16..255 execute as NOP)
//   - state_e                   : control FSM states
//   - instr_t                   : instruction word layout {operand, opcode}
// -----------------------------------------------------------------------------
package arisc_pkg;

    localparam int W_INSTR = 16;
    localparam int W_DATA  = 8;
    localparam int W_ADDR  = 8;

    typedef enum logic [7:0] {
        OP_END = 8'd0,
        OP_LDI = 8'd1,
        OP_MVR = 8'd2,
        OP_MVA = 8'd3,
        OP_ADD = 8'd4,
        OP_SUB = 8'd5,
        OP_AND = 8'd6,
        OP_OR  = 8'd7,
        OP_NOT = 8'd8,
        OP_LDM = 8'd9,
        OP_STM = 8'd10,
        OP_JMP = 8'd11,
        OP_JZ  = 8'd12,
        OP_INC = 8'd13,
        OP_DEC = 8'd14,
        OP_SHL = 8'd15
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_MEMRD
    } state_e;

    typedef struct packed {
        logic [W_DATA-1:0] operand;
        logic [7:0]        opcode;
    } instr_t;

endpackage

// File: rtl/mock_ram.sv
// -----------------------------------------------------------------------------
// mock_ram
//   Single-port synchronous RAM model used around the CPU for IRAM and DRAM.
//   Write on the rising edge when write_en is high; dout presents ram[addr]
//   delayed by LATENCY clocks (read-before-write on a same-address collision).
//   Ports:
//     clk       in   clock
//     write_en  in   write strobe
//     addr      in   word address
//     din       in   write data
//     dout      out  read data, LATENCY cycles after addr
// -----------------------------------------------------------------------------
module mock_ram #(
    parameter int W_DATA  = 8,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     write_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [W_DATA-1:0]        din,
    output logic [W_DATA-1:0]        dout
);

    // NOTE: memory arrays get no reset; clearing them would need a per-word
    // write port or a sequencer, and real RAM macros do not support it.
    logic [W_DATA-1:0] ram    [DEPTH];
    logic [W_DATA-1:0] pipe_q [LATENCY];

    always_ff @(posedge clk) begin
        if (write_en) begin
            ram[addr] <= din;
        end
        pipe_q[0] <= ram[addr];
        for (int i = 1; i < LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign dout = pipe_q[LATENCY-1];

endmodule

// File: rtl/arisc_cpu.sv
// -----------------------------------------------------------------------------
// arisc_cpu
//   8-bit accumulator CPU with NUM_GPR general registers and Harvard memory.
//   Runs from PC=0 on a start pulse until an END instruction, then idles.
//   Each instruction takes FETCH + EXEC; LDM adds a MEMRD cycle.
//   Ports:
//     clk         in   clock, rising edge
//     rst         in   synchronous active-high reset
//     start       in   1-cycle pulse, honoured only while idle
//     idle        out  high when no program is running
//     iram_addr   out  instruction address (= PC)
//     iram_dout   in   instruction word {operand, opcode}, 1 cycle latency
//     iram_write  out  IRAM write enable, tied low
//     dram_addr   out  data address
//     dram_din    out  store data (= ACC)
//     dram_dout   in   load data, 1 cycle after dram_addr
//     dram_write  out  1-cycle store strobe
// -----------------------------------------------------------------------------
module arisc_cpu
    import arisc_pkg::*;
#(
    parameter int NUM_GPR = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               idle,
    output logic [W_ADDR-1:0]  iram_addr,
    input  logic [W_INSTR-1:0] iram_dout,
    output logic               iram_write,
    output logic [W_ADDR-1:0]  dram_addr,
    output logic [W_DATA-1:0]  dram_din,
    input  logic [W_DATA-1:0]  dram_dout,
    output logic               dram_write
);

    localparam int             IDX_W   = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;
    localparam logic [IDX_W:0] GPR_CNT = NUM_GPR[IDX_W:0];

    state_e             state_q, state_d;
    logic [W_ADDR-1:0]  pc_q, pc_d;
    logic [W_DATA-1:0]  acc_q, acc_d;
    logic               z_q, z_d;
    logic [W_ADDR-1:0]  dram_addr_q, dram_addr_d;
    logic [W_DATA-1:0]  gpr_q [NUM_GPR];

    instr_t             instr;
    logic [IDX_W-1:0]   gpr_idx;
    logic               idx_ok;
    logic [W_DATA-1:0]  gpr_rd;
    logic               gpr_we;
    logic               acc_we;
    logic               exec_mem;

    // The word on iram_dout is only meaningful during EXEC, one cycle after
    // FETCH presented the PC.
    assign instr   = instr_t'(iram_dout);
    assign gpr_idx = instr.operand[IDX_W-1:0];
    // Indices past the register file read as zero and drop writes.
    assign idx_ok  = ({1'b0, gpr_idx} < GPR_CNT);
    assign gpr_rd  = idx_ok ? gpr_q[gpr_idx] : '0;

    assign exec_mem = (state_q == ST_EXEC) &&
                      ((instr.opcode == OP_LDM) || (instr.opcode == OP_STM));

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            acc_q       <= '0;
            z_q         <= 1'b0;
            dram_addr_q <= '0;
            // NOTE: the GPR file is a handful of flops with a defined reset
            // value, so unlike a RAM array it is cleared here.
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            acc_q       <= acc_d;
            z_q         <= z_d;
            dram_addr_q <= dram_addr_d;
            if (gpr_we) begin
                gpr_q[gpr_idx] <= acc_q;
            end
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_EXEC;
            ST_EXEC: begin
                if (instr.opcode == OP_END) begin
                    state_d = ST_IDLE;
                end else if (instr.opcode == OP_LDM) begin
                    state_d = ST_MEMRD;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEMRD: state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        pc_d        = pc_q;
        acc_d       = acc_q;
        z_d         = z_q;
        dram_addr_d = dram_addr_q;
        gpr_we      = 1'b0;
        acc_we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) pc_d = '0;
            end
            ST_EXEC: begin
                pc_d = pc_q + 1'b1;
                case (instr.opcode)
                    OP_END: pc_d = pc_q;
                    OP_LDI: begin acc_d = instr.operand;   acc_we = 1'b1; end
                    OP_MVR: gpr_we = idx_ok;
                    OP_MVA: begin acc_d = gpr_rd;          acc_we = 1'b1; end
                    OP_ADD: begin acc_d = acc_q + gpr_rd;  acc_we = 1'b1; end
                    OP_SUB: begin acc_d = acc_q - gpr_rd;  acc_we = 1'b1; end
                    OP_AND: begin acc_d = acc_q & gpr_rd;  acc_we = 1'b1; end
                    OP_OR:  begin acc_d = acc_q | gpr_rd;  acc_we = 1'b1; end
                    OP_NOT: begin acc_d = ~acc_q;          acc_we = 1'b1; end
                    OP_LDM: dram_addr_d = gpr_rd;
                    OP_STM: dram_addr_d = gpr_rd;
                    OP_JMP: pc_d = instr.operand;
                    OP_JZ:  if (z_q) pc_d = instr.operand;
                    OP_INC: begin acc_d = acc_q + 1'b1;    acc_we = 1'b1; end
                    OP_DEC: begin acc_d = acc_q - 1'b1;    acc_we = 1'b1; end
                    OP_SHL: begin acc_d = acc_q << 1;      acc_we = 1'b1; end
                    default: ;
                endcase
                // NOTE: blocking '=' here lets the flag read the acc_d value
                // just computed above; clocked blocks use '<=' only.
                if (acc_we) z_d = (acc_d == '0);
            end
            ST_MEMRD: begin
                acc_d = dram_dout;
                z_d   = (dram_dout == '0);
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // LDM/STM drive the address straight from the register during EXEC so the
    // RAM samples it on that edge: the store lands at the end of EXEC and the
    // load data is ready in MEMRD. dram_addr_q holds it afterwards.
    always_comb begin
        idle       = (state_q == ST_IDLE);
        iram_addr  = pc_q;
        iram_write = 1'b0;
        dram_din   = acc_q;
        dram_addr  = exec_mem ? gpr_rd : dram_addr_q;
        dram_write = (state_q == ST_EXEC) && (instr.opcode == OP_STM);
    end

endmodule

// File: tb/tb_arisc_cpu.sv
// -----------------------------------------------------------------------------
// tb_arisc_cpu
//   Directed bench for arisc_cpu with IRAM/DRAM mock_ram instances. The bench
//   loads memories through the RAM ports while the CPU is idle and inspects
//   results in DRAM and in CPU registers.
// -----------------------------------------------------------------------------
module tb_arisc_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        idle;
    logic [7:0]  iram_addr;
    logic [15:0] iram_dout;
    logic        iram_write;
    logic [7:0]  dram_addr;
    logic [7:0]  dram_din;
    logic [7:0]  dram_dout;
    logic        dram_write;

    // Memory loader, muxed onto the RAM ports while ld_mode is high.
    logic        ld_mode = 1'b0;
    logic        ld_i_we = 1'b0;
    logic [7:0]  ld_i_addr = '0;
    logic [15:0] ld_i_din = '0;
    logic        ld_d_we = 1'b0;
    logic [7:0]  ld_d_addr = '0;
    logic [7:0]  ld_d_din = '0;

    logic        iram_we_m, dram_we_m;
    logic [7:0]  iram_addr_m, dram_addr_m, dram_din_m;

    assign iram_we_m   = ld_mode ? ld_i_we   : iram_write;
    assign iram_addr_m = ld_mode ? ld_i_addr : iram_addr;
    assign dram_we_m   = ld_mode ? ld_d_we   : dram_write;
    assign dram_addr_m = ld_mode ? ld_d_addr : dram_addr;
    assign dram_din_m  = ld_mode ? ld_d_din  : dram_din;

    always #5 clk = ~clk;

    arisc_cpu #(.NUM_GPR(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .idle       (idle),
        .iram_addr  (iram_addr),
        .iram_dout  (iram_dout),
        .iram_write (iram_write),
        .dram_addr  (dram_addr),
        .dram_din   (dram_din),
        .dram_dout  (dram_dout),
        .dram_write (dram_write)
    );

    mock_ram #(.W_DATA(16), .DEPTH(256), .LATENCY(1)) u_iram (
        .clk      (clk),
        .write_en (iram_we_m),
        .addr     (iram_addr_m),
        .din      (ld_i_din),
        .dout     (iram_dout)
    );

    mock_ram #(.W_DATA(8), .DEPTH(256), .LATENCY(1)) u_dram (
        .clk      (clk),
        .write_en (dram_we_m),
        .addr     (dram_addr_m),
        .din      (dram_din_m),
        .dout     (dram_dout)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] prog [64];
    int          prog_len = 0;
    int          cyc;
    int          pre;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [15:0] w);
        prog[prog_len] = w;
        prog_len++;
    endtask

    task automatic load_iram();
        @(negedge clk);
        ld_mode = 1'b1;
        for (int i = 0; i < prog_len; i++) begin
            ld_i_addr = 8'(i);
            ld_i_din  = prog[i];
            ld_i_we   = 1'b1;
            @(negedge clk);
        end
        ld_i_we = 1'b0;
        ld_mode = 1'b0;
    endtask

    task automatic poke_dram(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_mode   = 1'b1;
        ld_d_addr = a;
        ld_d_din  = d;
        ld_d_we   = 1'b1;
        @(negedge clk);
        ld_d_we   = 1'b0;
        ld_mode   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges until idle, bounded by budget.
    task automatic wait_idle(input int budget, output int cnt);
        cnt = 0;
        while (!idle && cnt < budget) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic prog1();
        prog_len = 0;
        put(16'h0501); put(16'h0102); put(16'h0301); put(16'h0104);
        put(16'h0202); put(16'h0001); put(16'h0302); put(16'h0203);
        put(16'h030A); put(16'h0000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_idle",       32'(idle),       32'd1);
        check("rst_dram_write", 32'(dram_write), 32'd0);
        check("rst_iram_write", 32'(iram_write), 32'd0);
        check("rst_iram_addr",  32'(iram_addr),  32'h00);
        check("rst_dram_addr",  32'(dram_addr),  32'h00);
        check("rst_acc",        32'(u_dut.acc_q), 32'h00);
        check("rst_z",          32'(u_dut.z_q),  32'd0);
        repeat (5) @(negedge clk);
        check("idle_hold",      32'(idle),       32'd1);
        check("idle_pc_hold",   32'(iram_addr),  32'h00);

        // ---------------- program 1: 5+3 stored to DRAM[0]
        prog1();
        load_iram();
        poke_dram(8'h00, 8'h00);
        pulse_start();
        check("p1_busy", 32'(idle), 32'd0);
        wait_idle(100, cyc);
        check("p1_idle",   32'(idle),          32'd1);
        check("p1_cycles", 32'(cyc),           32'd20);
        check("p1_dram0",  32'(u_dram.ram[0]), 32'h08);
        check("p1_acc",    32'(u_dut.acc_q),   32'h08);
        check("p1_pc",     32'(u_dut.pc_q),    32'd9);

        // ---------------- program 2: wraparound, JZ taken, NOT/AND/SHL/OR, NOP
        do_reset();
        prog_len = 0;
        put(16'h0101); put(16'h0102); put(16'h0502); put(16'h0001); // 0..3
        put(16'h0105); put(16'h000A); put(16'h0001); put(16'h000E); // 4..7
        put(16'h050A); put(16'h000D); put(16'h0D0C); put(16'hAA01); // 8..11
        put(16'h0000); put(16'h5A01); put(16'h000F); put(16'h0602); // 12..15
        put(16'h0201); put(16'h0702); put(16'h0603); put(16'h070A); // 16..19
        put(16'h0008); put(16'h0606); put(16'h0020); put(16'h0607); // 20..23
        put(16'h0000);                                              // 24
        load_iram();
        poke_dram(8'h00, 8'h00);
        poke_dram(8'h01, 8'h00);
        poke_dram(8'h02, 8'h00);
        pulse_start();
        wait_idle(200, cyc);
        check("p2_cycles",   32'(cyc),           32'd46);
        check("p2_sub_wrap", 32'(u_dram.ram[0]), 32'hFF);
        check("p2_dec_wrap", 32'(u_dram.ram[1]), 32'hFF);
        check("p2_jz_shl",   32'(u_dram.ram[2]), 32'hB4);
        check("p2_acc",      32'(u_dut.acc_q),   32'hB4);
        check("p2_z",        32'(u_dut.z_q),     32'd0);
        check("p2_pc",       32'(u_dut.pc_q),    32'd24);

        // ---------------- program 3: store then load
        do_reset();
        prog_len = 0;
        put(16'h0901); put(16'h0102); put(16'h0701); put(16'h010A);
        put(16'h0001); put(16'h0109); put(16'h0402); put(16'h010A);
        put(16'h0000);
        load_iram();
        poke_dram(8'h09, 8'h00);
        pulse_start();
        wait_idle(100, cyc);
        check("p3_cycles", 32'(cyc),             32'd19);
        check("p3_dram9",  32'(u_dram.ram[9]),   32'h07);
        check("p3_r4",     32'(u_dut.gpr_q[4]),  32'h07);
        check("p3_z",      32'(u_dut.z_q),       32'd0);
        check("p3_acc",    32'(u_dut.acc_q),     32'h07);

        // ---------------- program 4: countdown loop with DEC/JZ/JMP
        do_reset();
        prog_len = 0;
        put(16'h0301); put(16'h0202); put(16'h0203); put(16'h010A);
        put(16'h0103); put(16'h000D); put(16'h0102); put(16'h0203);
        put(16'h000E); put(16'h0202); put(16'h0C0C); put(16'h020B);
        put(16'h0000);
        load_iram();
        poke_dram(8'h00, 8'h00);
        poke_dram(8'h01, 8'h00);
        poke_dram(8'h02, 8'h00);
        poke_dram(8'h03, 8'hEE);
        pulse_start();
        wait_idle(300, cyc);
        check("p4_cycles", 32'(cyc),           32'd64);
        check("p4_dram0",  32'(u_dram.ram[0]), 32'h03);
        check("p4_dram1",  32'(u_dram.ram[1]), 32'h02);
        check("p4_dram2",  32'(u_dram.ram[2]), 32'h01);
        check("p4_dram3",  32'(u_dram.ram[3]), 32'hEE);
        check("p4_pc",     32'(u_dut.pc_q),    32'd12);
        check("p4_z",      32'(u_dut.z_q),     32'd1);

        // ---------------- start while busy is ignored
        do_reset();
        prog1();
        load_iram();
        poke_dram(8'h00, 8'h00);
        pulse_start();
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pre = 5;
        wait_idle(100, cyc);
        check("busy_start_cycles", 32'(pre + cyc),    32'd20);
        check("busy_start_dram0",  32'(u_dram.ram[0]), 32'h08);

        // ---------------- reset mid-run, then rerun
        poke_dram(8'h00, 8'h00);
        pulse_start();
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_idle", 32'(idle),         32'd1);
        check("midrst_pc",   32'(u_dut.pc_q),   32'd0);
        check("midrst_acc",  32'(u_dut.acc_q),  32'h00);
        check("midrst_r1",   32'(u_dut.gpr_q[1]), 32'h00);
        repeat (3) @(negedge clk);
        check("midrst_stays_idle", 32'(idle),           32'd1);
        check("midrst_no_store",   32'(u_dram.ram[0]),  32'h00);
        pulse_start();
        wait_idle(100, cyc);
        check("rerun_cycles", 32'(cyc),           32'd20);
        check("rerun_dram0",  32'(u_dram.ram[0]), 32'h08);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
